key_search_scheduler: RTL
=========================

Name: key_search_scheduler

Overview:
- Parallel RC4 key-search controller. Hands consecutive candidate keys to NUM_CORES decryption-core slots, each slot being a decryption_core plus determine_valid_message pair with its own s_memory.
- Tracks which slots are busy, collects per-slot pass/fail results and stops the search on the first valid key.
- Replaces the single-key START_GEN_KEY/DECRYPT/DETERMINE loop in the ksa top level. Sits between the ROM-D load sequencer and the core slots; drives LEDR/HEX status in ksa.

Parameters:
- NUM_CORES, 4, number of decryption-core slots (1..16).
- KEY_WIDTH, 24, width of secret_key bus.
- KEY_FIRST, 24'h000000, first key dispatched.
- KEY_MAX, 24'h3FFFFF, last key dispatched (inclusive); only the 22-bit space is searched.

Ports:
- clk  in  1  system clock (CLOCK_50).
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse: begin a search; ROM-D must already be loaded.
- core_start  out  NUM_CORES  one-cycle per-slot pulse: latch core_key and run.
- core_key  out  NUM_CORES*KEY_WIDTH  per-slot key; slot i uses bits [i*KEY_WIDTH +: KEY_WIDTH]; held from core_start until that slot's core_done.
- core_abort  out  1  one-cycle pulse to all slots: drop the current key and return to idle.
- core_done  in  NUM_CORES  per-slot one-cycle pulse: key checked.
- core_valid  in  NUM_CORES  per-slot result; qualified by core_done.
- busy  out  1  high while searching (DISPATCH or DRAIN).
- found  out  1  sticky: valid key located.
- not_found  out  1  sticky: key space exhausted.
- found_key  out  KEY_WIDTH  winning key; valid while found=1.
- found_core  out  clog2(NUM_CORES)  index of the winning slot.
- keys_checked  out  KEY_WIDTH  count of core_done pulses received this search; saturates at all-ones.

Behaviour:
- Reset (reset_n=0 at a clock edge): state=IDLE; all outputs 0; all slot busy bits cleared; next_key=KEY_FIRST. Applies mid-search with no drain; the top level also resets the slots.
- States: IDLE, DISPATCH, DRAIN, FOUND, NOT_FOUND.
- IDLE: on start -> DISPATCH. Clear found, not_found and keys_checked; set next_key=KEY_FIRST.
- DISPATCH, per cycle, at most one key is issued:
  - Target is the lowest-index slot whose busy bit is clear, evaluated after this cycle's core_done has freed slots. A slot whose done arrives at cycle t may be restarted in cycle t.
  - Issuing drives core_start[i]=1 and core_key[i]=next_key, sets busy[i], and increments next_key.
  - Issuing KEY_MAX -> DRAIN. No further keys; next_key does not wrap.
- First core_start is issued the cycle after start, so latency start->core_start[0] is 1 cycle.
- Result handling (DISPATCH or DRAIN): any core_done[i] clears busy[i] and increments keys_checked.
  - If any core_done[i]&core_valid[i] occurs at cycle t, the lowest such index wins.
  - At t+1: found=1, found_key = the key that slot holds, found_core=i, core_abort pulses, all busy bits clear, state -> FOUND.
  - No core_start is issued in cycle t; a valid result pre-empts dispatch.
- DRAIN: when no busy bits remain and no valid result arrived -> NOT_FOUND, with not_found=1 the next cycle.
- FOUND / NOT_FOUND: outputs hold. start re-enters DISPATCH from KEY_FIRST and clears the flags.
- start while busy=1 is ignored.
- core_done from a non-busy slot is ignored (does not count, does not win). The bench flags it as a protocol error.
- Slots latch core_key on core_start; the scheduler keeps a per-slot key register so found_key is exact under out-of-order completion.
- busy = (state==DISPATCH || state==DRAIN).

Decomposition:
- Package key_search_pkg:
  - state enum sched_state_t;
  - KEY_WIDTH_DEFAULT=24 and KEY_SPACE_MAX=24'h3FFFFF;
  - function idx_width(n) for found_core sizing.
- Sub-module lowest_index_picker (parameter N): combinational lowest-set-bit encoder, output index + any. Instantiated twice: free-slot selection and valid-winner selection.

Test Plan:
- NUM_CORES=4, KEY_MAX=15, no core ever valid, done 5 cycles after each start:
  - keys 0..3 go to slots 0..3 on cycles 1..4;
  - not_found=1 after the last done;
  - keys_checked=16; found stays 0.
- NUM_CORES=4, KEY_MAX=15, only key 9 valid: found=1, found_key=9, found_core=slot that received 9, one core_abort pulse, no core_start after the winning done.
- Slots 1 and 3 both report core_done&core_valid in the same cycle (keys 5, 7) -> found_core=1, found_key=5.
- Slot 2 done at cycle t while slots 0,1,3 busy -> core_start[2] in cycle t with the next key; no duplicate or skipped key across the whole run.
- reset_n low for 1 cycle while 3 slots busy -> next cycle all outputs 0, state IDLE; stray core_done afterwards is ignored; a fresh start redispatches key 0.
- start pulsed during DISPATCH is ignored (no key reset). start in FOUND restarts from 0 with found cleared the next cycle.

Source files
------------

// File: rtl/key_search_pkg.sv
// Shared types and helpers for the parallel RC4 key-search scheduler.
package key_search_pkg;

    // Scheduler states: idle, handing out keys, waiting for stragglers, and the two end states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISPATCH  = 3'd1,
        ST_DRAIN     = 3'd2,
        ST_FOUND     = 3'd3,
        ST_NOT_FOUND = 3'd4
    } sched_state_t;

    localparam int          KEY_WIDTH_DEFAULT = 24;
    localparam logic [23:0] KEY_SPACE_MAX     = 24'h3FFFFF;

    // Width of a slot index; never below one bit so a single-slot build still has a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/lowest_index_picker.sv
// Combinational lowest-set-bit encoder: returns the index of the lowest request and a hit flag.
module lowest_index_picker
    import key_search_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req,
    output logic [idx_width(N)-1:0]   idx,
    output logic                      any
);

    localparam int IW = idx_width(N);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IW'(i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/key_search_scheduler.sv
// Parallel RC4 key-search controller: deals consecutive keys to NUM_CORES core slots,
// collects per-slot results and stops on the first valid key.
module key_search_scheduler
    import key_search_pkg::*;
#(
    parameter int                   NUM_CORES = 4,
    parameter int                   KEY_WIDTH = KEY_WIDTH_DEFAULT,
    parameter logic [KEY_WIDTH-1:0] KEY_FIRST = '0,
    parameter logic [KEY_WIDTH-1:0] KEY_MAX   = KEY_WIDTH'(KEY_SPACE_MAX)
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    output logic [NUM_CORES-1:0]               core_start,
    output logic [NUM_CORES*KEY_WIDTH-1:0]     core_key,
    output logic                               core_abort,
    input  logic [NUM_CORES-1:0]               core_done,
    input  logic [NUM_CORES-1:0]               core_valid,
    output logic                               busy,
    output logic                               found,
    output logic                               not_found,
    output logic [KEY_WIDTH-1:0]               found_key,
    output logic [idx_width(NUM_CORES)-1:0]    found_core,
    output logic [KEY_WIDTH-1:0]               keys_checked
);

    localparam int IDX_W = idx_width(NUM_CORES);

    sched_state_t         state_reg;
    logic [NUM_CORES-1:0] busy_bits_reg;
    logic [KEY_WIDTH-1:0] slot_key_reg [NUM_CORES];
    logic [KEY_WIDTH-1:0] next_key_reg;
    logic [KEY_WIDTH-1:0] keys_checked_reg;
    logic [KEY_WIDTH-1:0] found_key_reg;
    logic [IDX_W-1:0]     found_core_reg;
    logic                 found_reg;
    logic                 not_found_reg;
    logic                 core_abort_reg;

    logic                 searching;
    logic [NUM_CORES-1:0] done_eff;
    logic [NUM_CORES-1:0] win_req;
    logic [NUM_CORES-1:0] busy_after;
    logic [NUM_CORES-1:0] free_req;
    logic [NUM_CORES-1:0] issue_onehot;
    logic                 issue_en;
    logic [IDX_W-1:0]     free_idx;
    logic [IDX_W-1:0]     win_idx;
    logic                 free_any;
    logic                 win_any;
    logic [KEY_WIDTH:0]   done_count;
    logic [KEY_WIDTH:0]   checked_sum;
    logic [KEY_WIDTH-1:0] keys_checked_next;

    // Results only count from slots we actually handed a key to; stray dones are dropped here.
    assign searching  = (state_reg == ST_DISPATCH) || (state_reg == ST_DRAIN);
    assign done_eff   = searching ? (core_done & busy_bits_reg) : '0;
    assign win_req    = done_eff & core_valid;
    assign busy_after = busy_bits_reg & ~done_eff;
    assign free_req   = ~busy_after;

    lowest_index_picker #(.N(NUM_CORES)) u_free_pick (
        .req (free_req),
        .idx (free_idx),
        .any (free_any)
    );

    lowest_index_picker #(.N(NUM_CORES)) u_win_pick (
        .req (win_req),
        .idx (win_idx),
        .any (win_any)
    );

    // Issue decision is same-cycle so a slot finishing now can be refilled now; a winner blocks it.
    always_comb begin
        issue_en     = (state_reg == ST_DISPATCH) && !win_any && free_any;
        issue_onehot = issue_en ? (NUM_CORES'(1) << free_idx) : '0;
    end

    // Saturating count of accepted core_done pulses.
    always_comb begin
        done_count = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            done_count = done_count + (KEY_WIDTH + 1)'(done_eff[i]);
        end
        checked_sum       = {1'b0, keys_checked_reg} + done_count;
        keys_checked_next = checked_sum[KEY_WIDTH] ? '1 : checked_sum[KEY_WIDTH-1:0];
    end

    // A freshly issued slot sees next_key directly; afterwards it sees its held key.
    generate
        for (genvar gi = 0; gi < NUM_CORES; gi++) begin : g_core_key
            assign core_key[gi*KEY_WIDTH +: KEY_WIDTH] =
                issue_onehot[gi] ? next_key_reg : slot_key_reg[gi];
        end
    endgenerate

    assign core_start   = issue_onehot;
    assign core_abort   = core_abort_reg;
    assign busy         = searching;
    assign found        = found_reg;
    assign not_found    = not_found_reg;
    assign found_key    = found_key_reg;
    assign found_core   = found_core_reg;
    assign keys_checked = keys_checked_reg;

    // Scheduler FSM: slot bookkeeping, key sequencing and the sticky result registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg        <= ST_IDLE;
            busy_bits_reg    <= '0;
            next_key_reg     <= KEY_FIRST;
            keys_checked_reg <= '0;
            found_key_reg    <= '0;
            found_core_reg   <= '0;
            found_reg        <= 1'b0;
            not_found_reg    <= 1'b0;
            core_abort_reg   <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                slot_key_reg[i] <= '0;
            end
        end else begin
            core_abort_reg <= 1'b0;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (issue_onehot[i]) begin
                    slot_key_reg[i] <= next_key_reg;
                end
            end

            case (state_reg)
                ST_IDLE, ST_FOUND, ST_NOT_FOUND: begin
                    if (start) begin
                        state_reg        <= ST_DISPATCH;
                        busy_bits_reg    <= '0;
                        next_key_reg     <= KEY_FIRST;
                        keys_checked_reg <= '0;
                        found_key_reg    <= '0;
                        found_core_reg   <= '0;
                        found_reg        <= 1'b0;
                        not_found_reg    <= 1'b0;
                    end
                end

                ST_DISPATCH, ST_DRAIN: begin
                    keys_checked_reg <= keys_checked_next;
                    if (win_any) begin
                        // The winner's key comes from our own copy, so completion order is irrelevant.
                        state_reg      <= ST_FOUND;
                        found_reg      <= 1'b1;
                        found_key_reg  <= slot_key_reg[win_idx];
                        found_core_reg <= win_idx;
                        core_abort_reg <= 1'b1;
                        busy_bits_reg  <= '0;
                    end else begin
                        busy_bits_reg <= busy_after | issue_onehot;
                        if (issue_en) begin
                            // The last key parks the counter rather than wrapping it.
                            if (next_key_reg == KEY_MAX) begin
                                state_reg <= ST_DRAIN;
                            end else begin
                                next_key_reg <= next_key_reg + 1'b1;
                            end
                        end else if ((state_reg == ST_DRAIN) && (busy_after == '0)) begin
                            state_reg     <= ST_NOT_FOUND;
                            not_found_reg <= 1'b1;
                        end
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
